// File: rtl/ddr_read_bridge.sv
// Splits a 512-bit line read into two 256-bit controller reads and reassembles the beats.
// Optional one-line result cache is enabled by defining DDR_RD_LINE_CACHE_EN.
module ddr_read_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 512,
  parameter int BEAT_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ddr_rd,
  input  logic [ADDR_WIDTH-1:0] readAdd,
  output logic                  ddr_rd_valid,
  output logic                  ddr_rd_done,
  output logic [LINE_WIDTH-1:0] ddr_rd_data,
  output logic                  app_en,
  output logic [2:0]            app_cmd,
  output logic [ADDR_WIDTH-1:0] app_addr,
  input  logic                  app_rdy,
  input  logic [BEAT_WIDTH-1:0] app_rd_data,
  input  logic                  app_rd_data_valid,
  output logic                  rd_err
);

  typedef enum logic [2:0] {IDLE, CMD0, CMD1, WAIT_DATA, RESP} state_t;

  state_t                state;
  logic [1:0]            beat_cnt;
  logic [LINE_WIDTH-1:0] line_buf;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] base_in;
  logic                  beat_ok;
  logic                  take_beat;
  logic                  bad_beat;
  logic                  hit;
  logic                  unused_low_bits;

  // Bit address to byte address of a 64-byte aligned line.
  assign base_in         = {3'b000, readAdd[ADDR_WIDTH-1:9], 6'b000000};
  assign unused_low_bits = &{1'b0, readAdd[8:0]};
  assign app_cmd         = 3'b001;

  always_comb begin
    beat_ok = 1'b0;
    case (state)
      CMD0:      beat_ok = app_rdy;
      CMD1:      beat_ok = 1'b1;
      WAIT_DATA: beat_ok = 1'b1;
      default:   beat_ok = 1'b0;
    endcase
    if (beat_cnt == 2'd2) beat_ok = 1'b0;
  end

  assign take_beat = app_rd_data_valid & beat_ok;
  assign bad_beat  = app_rd_data_valid & ~beat_ok;

`ifdef DDR_RD_LINE_CACHE_EN
  logic [ADDR_WIDTH-1:0] tag_addr;
  logic                  tag_valid;
  // The delivered line stays in ddr_rd_data, so the tag only needs the address.
  assign hit = tag_valid && (tag_addr == base_in);
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      beat_cnt     <= 2'd0;
      line_buf     <= '0;
      base         <= '0;
      ddr_rd_valid <= 1'b0;
      ddr_rd_done  <= 1'b0;
      ddr_rd_data  <= '0;
      app_en       <= 1'b0;
      app_addr     <= '0;
      rd_err       <= 1'b0;
`ifdef DDR_RD_LINE_CACHE_EN
      tag_addr     <= '0;
      tag_valid    <= 1'b0;
`endif
    end else begin
      ddr_rd_valid <= 1'b0;
      ddr_rd_done  <= 1'b0;
      if (bad_beat) rd_err <= 1'b1;
      if (take_beat) begin
        if (beat_cnt == 2'd0) line_buf[BEAT_WIDTH-1:0] <= app_rd_data;
        else                  line_buf[LINE_WIDTH-1:BEAT_WIDTH] <= app_rd_data;
        beat_cnt <= beat_cnt + 2'd1;
      end
      case (state)
        IDLE: begin
          if (ddr_rd) begin
            if (hit) begin
              ddr_rd_valid <= 1'b1;
              ddr_rd_done  <= 1'b1;
              state        <= RESP;
            end else begin
              base     <= base_in;
              app_addr <= base_in;
              app_en   <= 1'b1;
              beat_cnt <= 2'd0;
              state    <= CMD0;
            end
          end
        end
        CMD0: begin
          if (app_rdy) begin
            app_addr <= base + ADDR_WIDTH'(32);
            state    <= CMD1;
          end
        end
        CMD1: begin
          if (app_rdy) begin
            app_en <= 1'b0;
            state  <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (beat_cnt == 2'd2 || (take_beat && beat_cnt == 2'd1)) begin
            if (beat_cnt == 2'd2) ddr_rd_data <= line_buf;
            else                  ddr_rd_data <= {app_rd_data, line_buf[BEAT_WIDTH-1:0]};
            ddr_rd_valid <= 1'b1;
            ddr_rd_done  <= 1'b1;
            state        <= RESP;
`ifdef DDR_RD_LINE_CACHE_EN
            tag_addr     <= base;
            tag_valid    <= 1'b1;
`endif
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
